regfile_writeback: RTL

Writeback queue that acts as the sole writer of `registerfile`. Accepts results from the memory and ALU paths over valid/ready handshakes, buffers them in an in-order FIFO, and drives `RD`/`WriteData`/`RegWrite` from a registered output stage, one write per cycle. Also reports to decode whether a source register has a write still in flight, and optionally forwards its newest pending value.

---
 rtl/regfile_writeback.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/regfile_writeback.sv
`default_nettype none
// ============================================================================
// Module      : regfile_writeback
// Description : In-order writeback FIFO. It is the single writer of the
//               register file, using a registered RD/WriteData/RegWrite stage.
//               It also provides pending flags for decode. Newest-value
//               forwarding is built only when REGFILE_WB_BYPASS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_writeback #(
    parameter int DEPTH      = 4,
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  Clock,
    input  logic                  ResetN,
    input  logic                  MemValid,
    input  logic [ADDR_WIDTH-1:0] MemRD,
    input  logic [DATA_WIDTH-1:0] MemData,
    output logic                  MemReady,
    input  logic                  AluValid,
    input  logic [ADDR_WIDTH-1:0] AluRD,
    input  logic [DATA_WIDTH-1:0] AluData,
    output logic                  AluReady,
    output logic [ADDR_WIDTH-1:0] RD,
    output logic [DATA_WIDTH-1:0] WriteData,
    output logic                  RegWrite,
    input  logic [ADDR_WIDTH-1:0] RS,
    input  logic [ADDR_WIDTH-1:0] RT,
    output logic                  PendRS,
    output logic                  PendRT,
    output logic [DATA_WIDTH-1:0] FwdRS,
    output logic [DATA_WIDTH-1:0] FwdRT,
    output logic [ADDR_WIDTH-1:0] Level
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q,  count_d;
    logic [ADDR_WIDTH-1:0] fifo_rd_q   [DEPTH];
    logic [DATA_WIDTH-1:0] fifo_data_q [DEPTH];

    logic [ADDR_WIDTH-1:0] rd_q, rd_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  regwrite_q, regwrite_d;

    logic                  w_not_full;
    logic                  w_mem_fire;
    logic                  w_alu_fire;
    logic                  w_push;
    logic                  w_pop;
    logic [ADDR_WIDTH-1:0] w_push_rd;
    logic [DATA_WIDTH-1:0] w_push_data;
    logic                  w_pend_rs;
    logic                  w_pend_rt;

    // Ready looks only at registered occupancy, so a same-edge pop never frees a slot.
    assign w_not_full  = (count_q < CNT_W'(DEPTH));
    assign MemReady    = w_not_full;
    assign AluReady    = w_not_full && !MemValid;
    assign w_mem_fire  = MemValid && MemReady;
    assign w_alu_fire  = AluValid && AluReady;
    assign w_push      = w_mem_fire || w_alu_fire;
    assign w_push_rd   = w_mem_fire ? MemRD   : AluRD;
    assign w_push_data = w_mem_fire ? MemData : AluData;
    assign w_pop       = (count_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        rd_d       = rd_q;
        data_d     = data_q;
        regwrite_d = 1'b0;
        if (w_pop) begin
            rd_d       = fifo_rd_q[rd_ptr_q];
            data_d     = fifo_data_q[rd_ptr_q];
            regwrite_d = 1'b1;
        end
    end

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rd_q       <= '0;
            data_q     <= '0;
            regwrite_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rd_q       <= rd_d;
            data_q     <= data_d;
            regwrite_q <= regwrite_d;
        end
    end

    // Storage needs no reset; validity is tracked by the pointers and count.
    always_ff @(posedge Clock) begin
        if (w_push) begin
            fifo_rd_q[wr_ptr_q]   <= w_push_rd;
            fifo_data_q[wr_ptr_q] <= w_push_data;
        end
    end

    always_comb begin
        w_pend_rs = regwrite_q && (rd_q == RS);
        w_pend_rt = regwrite_q && (rd_q == RT);
        for (int i = 0; i < DEPTH; i++) begin
            if (CNT_W'(i) < count_q) begin
                if (fifo_rd_q[rd_ptr_q + PTR_W'(i)] == RS) w_pend_rs = 1'b1;
                if (fifo_rd_q[rd_ptr_q + PTR_W'(i)] == RT) w_pend_rt = 1'b1;
            end
        end
    end

`ifdef REGFILE_WB_BYPASS_EN
    logic [DATA_WIDTH-1:0] w_fwd_rs;
    logic [DATA_WIDTH-1:0] w_fwd_rt;

    // Walk oldest to newest so the youngest match is the last one assigned.
    always_comb begin
        w_fwd_rs = (regwrite_q && (rd_q == RS)) ? data_q : '0;
        w_fwd_rt = (regwrite_q && (rd_q == RT)) ? data_q : '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CNT_W'(i) < count_q) begin
                if (fifo_rd_q[rd_ptr_q + PTR_W'(i)] == RS) w_fwd_rs = fifo_data_q[rd_ptr_q + PTR_W'(i)];
                if (fifo_rd_q[rd_ptr_q + PTR_W'(i)] == RT) w_fwd_rt = fifo_data_q[rd_ptr_q + PTR_W'(i)];
            end
        end
    end

    assign FwdRS = w_fwd_rs;
    assign FwdRT = w_fwd_rt;
`else
    assign FwdRS = '0;
    assign FwdRT = '0;
`endif

    assign PendRS    = w_pend_rs;
    assign PendRT    = w_pend_rt;
    assign RD        = rd_q;
    assign WriteData = data_q;
    assign RegWrite  = regwrite_q;
    assign Level     = ADDR_WIDTH'(count_q);

endmodule
`default_nettype wire
